button_buzzer_arbiter: RTL

BUTTON_BUZZER_ARBITER -- requirements
Module: button_buzzer_arbiter

---
 rtl/button_buzzer_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/button_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// button_buzzer_arbiter
//
// Five push-buttons share one buzzer. Each raw button is synchronized and
// debounced. A rising debounced level queues a request, and a round-robin FSM
// serves the queue one requester at a time. A request is served as a tone
// burst (BEEP) followed by a silent gap (GAP). Each requester gets its own
// pitch: the buzzer is driven by a tone-counter bit chosen per requester.
//
// Ports
//   clk        : system clock; all logic runs on the rising edge
//   rst_n      : asynchronous active-low reset
//   buttons    : raw asynchronous buttons, active-high
//                (bit0 drops, bit1 hoods, bit2 tops, bit3 bar, bit4 seat)
//   BOARD_LEDs : debounced level of each button
//   BUZZER     : square-wave tone of the granted requester, 0 otherwise
//   grant      : one-hot requester currently beeping, 0 otherwise
//   pending    : queued requests that have not been served yet
//   busy       : high while in BEEP or GAP
// -----------------------------------------------------------------------------
module button_buzzer_arbiter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BEEP_CYCLES     = 5000000,
  parameter int GAP_CYCLES      = 2500000,
  parameter int TONE_BIT        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] buttons,
  output logic [4:0] BOARD_LEDs,
  output logic       BUZZER,
  output logic [4:0] grant,
  output logic [4:0] pending,
  output logic       busy
);

  localparam int N   = 5;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]    BEEP_LAST = 32'(BEEP_CYCLES - 1);
  localparam logic [31:0]    GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

  logic [4:0]     sync1_q, sync2_q;
  logic [4:0]     deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0] db_cnt_q [N];
  logic [DBW-1:0] db_cnt_d [N];
  logic [4:0]     rise;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] tone_q, tone_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  pend_q, pend_d;
  logic [4:0]  grant_q, grant_d;
  logic        buzz_q, buzz_d;
  logic        busy_q, busy_d;
  logic [4:0]  clr;
  logic        start;
  logic [3:0]  pick_r;

  // Round-robin pick: first set request at or after ptr (mod 5).
  // Returns {found, index}. Scanning offsets from high to low lets the
  // smallest offset win.
  function automatic logic [3:0] pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] r;
    int         idx;
    logic [2:0] idx3;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx -= N;
      idx3 = 3'(idx);
      if (req[idx3]) r = {1'b1, idx3};
    end
    return r;
  endfunction

  // Tone bit for a requester: higher index -> higher bit -> lower pitch.
  function automatic logic tone_bit(input logic [31:0] t, input logic [2:0] sel);
    logic [31:0] s;
    s = t >> (TONE_BIT + int'(sel));
    return s[0];
  endfunction

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; any matching cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    tone_d  = tone_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    buzz_d  = 1'b0;
    clr     = '0;
    start   = 1'b0;
    pick_r  = pick(pend_q, ptr_q);

    unique case (state_q)
      IDLE: start = pick_r[3];
      BEEP: begin
        tone_d = tone_q + 32'd1;
        if (tmr_q == BEEP_LAST) begin
          state_d = GAP;
          tmr_d   = '0;
          grant_d = '0;
        end else begin
          tmr_d  = tmr_q + 32'd1;
          // Buzzer is registered, so present the bit of the next tone value.
          buzz_d = tone_bit(tone_q + 32'd1, sel_q);
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          if (pick_r[3]) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            tmr_d   = '0;
          end
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = BEEP;
      tmr_d   = '0;
      tone_d  = '0;
      sel_d   = pick_r[2:0];
      grant_d = 5'b00001 << pick_r[2:0];
      clr     = grant_d;
      ptr_d   = (pick_r[2:0] == 3'd4) ? 3'd0 : pick_r[2:0] + 3'd1;
      buzz_d  = 1'b0;
    end

    // A rise on the same edge as its own clear leaves the request queued.
    pend_d = (pend_q & ~clr) | rise;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < N; i++) db_cnt_q[i] <= '0;
      state_q    <= IDLE;
      tmr_q      <= '0;
      tone_q     <= '0;
      ptr_q      <= '0;
      sel_q      <= '0;
      pend_q     <= '0;
      grant_q    <= '0;
      buzz_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= buttons;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < N; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tone_q     <= tone_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      buzz_q     <= buzz_d;
      busy_q     <= busy_d;
    end
  end

  assign BOARD_LEDs = deb_q;
  assign BUZZER     = buzz_q;
  assign grant      = grant_q;
  assign pending    = pend_q;
  assign busy       = busy_q;

endmodule
